// File: rtl/adc_capture_pkg.sv
// adc_capture shared types and defaults
// FSM state encoding plus default block parameters
package adc_capture_pkg;

  localparam int DEF_DATA_W       = 10;
  localparam int DEF_NUM_SAMPLES  = 2;
  localparam int DEF_CONV_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    SOC,
    WAIT_BUSY,
    CONV,
    LATCH,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/adc_capture_if.sv
// adc_capture ADC-side bus
// master = capture logic, slave = ADC
interface adc_capture_if #(
  parameter int DATA_W = 10
);

  logic              adc_soc;
  logic              adc_busy;
  logic [DATA_W-1:0] adc_data;

  modport master (
    output adc_soc,
    input  adc_busy,
    input  adc_data
  );

  modport slave (
    input  adc_soc,
    output adc_busy,
    output adc_data
  );

endinterface

// File: rtl/adc_capture_conv_timer.sv
// adc_capture phase timer
// counts cycles spent in one wait phase
module conv_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // high in the phase cycle whose edge brings the count to TIMEOUT
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// adc_capture top: ADC handshake sequencer
// runs NUM_SAMPLES conversions and accumulates them
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  adc_capture_if.master     adc,
  output logic [DATA_W-1:0] sample,
  output logic              eoc,
  output logic [DATA_W+2:0] sum,
  output logic              complete,
  output logic              timeout_err
);

  localparam int CNT_W = 4;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tmr_en;
  logic             tmr_clear;
  logic             expired;

  assign tmr_en = (state == WAIT_BUSY) ||
                  (state == CONV);

  // restart when entering CONV from WAIT_BUSY
  assign tmr_clear = !tmr_en ||
                     ((state == WAIT_BUSY) &&
                      adc.adc_busy);

  conv_timer #(
    .TIMEOUT (CONV_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      adc.adc_soc <= 1'b0;
      eoc         <= 1'b0;
      complete    <= 1'b0;
      timeout_err <= 1'b0;
      sample      <= '0;
      sum         <= '0;
      cnt         <= '0;
    end else begin
      adc.adc_soc <= 1'b0;
      eoc         <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            sum         <= '0;
            cnt         <= '0;
            complete    <= 1'b0;
            timeout_err <= 1'b0;
            adc.adc_soc <= 1'b1;
            state       <= SOC;
          end
        end
        SOC: begin
          if (stop) begin
            complete <= 1'b1;
            state    <= DONE;
          end else begin
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (stop) begin
            complete <= 1'b1;
            state    <= DONE;
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= ERR;
          end else if (adc.adc_busy) begin
            state <= CONV;
          end
        end
        CONV: begin
          if (stop) begin
            complete <= 1'b1;
            state    <= DONE;
          end else if (expired) begin
            timeout_err <= 1'b1;
            state       <= ERR;
          end else if (!adc.adc_busy) begin
            // result is captured as LATCH is entered
            sample <= adc.adc_data;
            sum    <= sum + {3'b000, adc.adc_data};
            eoc    <= 1'b1;
            cnt    <= cnt + 1'b1;
            state  <= LATCH;
          end
        end
        LATCH: begin
          if (stop ||
              (cnt == CNT_W'(NUM_SAMPLES))) begin
            complete <= 1'b1;
            state    <= DONE;
          end else begin
            adc.adc_soc <= 1'b1;
            state       <= SOC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// adc_capture directed bench
// two instances: default config and NUM_SAMPLES=8
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        start8 = 1'b0;
  logic        stop8 = 1'b0;
  logic [9:0]  sample, sample8;
  logic [12:0] sum, sum8;
  logic        eoc, eoc8;
  logic        complete, complete8;
  logic        terr, terr8;

  int checks = 0;
  int errors = 0;

  adc_capture_if #(.DATA_W(10)) a ();
  adc_capture_if #(.DATA_W(10)) a8 ();

  adc_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .adc         (a.master),
    .sample      (sample),
    .eoc         (eoc),
    .sum         (sum),
    .complete    (complete),
    .timeout_err (terr)
  );

  adc_capture #(.NUM_SAMPLES(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start8),
    .stop        (stop8),
    .adc         (a8.master),
    .sample      (sample8),
    .eoc         (eoc8),
    .sum         (sum8),
    .complete    (complete8),
    .timeout_err (terr8)
  );

  always #5 clk = ~clk;

  logic [9:0] vals [8];
  logic [9:0] vals8 [8];
  int vidx = 0;
  int vidx8 = 0;
  bit stuck = 1'b0;

  initial begin
    a.adc_busy = 1'b0;
    a.adc_data = '0;
    forever begin
      @(negedge clk);
      if (a.adc_soc === 1'b1 && !stuck) begin
        @(negedge clk);
        a.adc_busy = 1'b1;
        a.adc_data = '0;
        repeat (5) @(negedge clk);
        a.adc_busy = 1'b0;
        a.adc_data = vals[vidx];
        vidx++;
      end
    end
  end

  initial begin
    a8.adc_busy = 1'b0;
    a8.adc_data = '0;
    forever begin
      @(negedge clk);
      if (a8.adc_soc === 1'b1) begin
        @(negedge clk);
        a8.adc_busy = 1'b1;
        a8.adc_data = '0;
        repeat (5) @(negedge clk);
        a8.adc_busy = 1'b0;
        a8.adc_data = vals8[vidx8];
        vidx8++;
      end
    end
  end

  int eoc_cnt = 0;
  int eoc8_cnt = 0;
  int soc_cnt = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int lat = -1;
  logic busy_q = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (busy_q && !a.adc_busy) fall_cyc = cyc;
      if (eoc === 1'b1) begin
        eoc_cnt++;
        lat = cyc - fall_cyc;
      end
      if (eoc8 === 1'b1) eoc8_cnt++;
      if (a.adc_soc === 1'b1) soc_cnt++;
      busy_q = a.adc_busy;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag,
                          input int lim);
    int n = 0;
    while (!(complete || terr) && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic wait_busy(input string tag,
                           input int lim);
    int n = 0;
    while (!a.adc_busy && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(n < lim), 32'd1);
  endtask

  task automatic clr();
    repeat (12) step();
    vidx = 0;
    eoc_cnt = 0;
    soc_cnt = 0;
    lat = -1;
  endtask

  initial begin
    int n;
    vals[0] = 10'h155;
    vals[1] = 10'h0AA;
    for (int i = 0; i < 8; i++)
      vals8[i] = 10'h3FF;
    #1;
    chk("rst_soc", 32'(a.adc_soc), 0);
    chk("rst_eoc", 32'(eoc), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cmp", 32'(complete), 0);
    chk("rst_terr", 32'(terr), 0);
    chk("rst_smp", 32'(sample), 0);
    step();
    rst_n = 1'b1;
    step();

    // nominal run
    clr();
    step();
    do_start();
    chk("soc_lat", 32'(a.adc_soc), 1);
    step();
    chk("soc_1cyc", 32'(a.adc_soc), 0);
    wait_end("nom_end", 100);
    chk("nom_eoc", 32'(eoc_cnt), 2);
    chk("nom_smp", 32'(sample), 32'h0AA);
    chk("nom_sum", 32'(sum), 32'h1FF);
    chk("nom_cmp", 32'(complete), 1);
    chk("nom_terr", 32'(terr), 0);
    chk("eoc_lat", 32'(lat), 1);
    chk("nom_soc", 32'(soc_cnt), 2);

    // no response
    clr();
    stuck = 1'b1;
    do_start();
    repeat (255) step();
    chk("to_early", 32'(terr), 0);
    step();
    chk("to_terr", 32'(terr), 1);
    chk("to_cmp", 32'(complete), 0);
    chk("to_sum", 32'(sum), 0);
    chk("to_eoc", 32'(eoc_cnt), 0);
    repeat (20) step();
    chk("to_hold", 32'(terr), 1);
    stuck = 1'b0;

    // start from ERR, with a start pulse in CONV
    clr();
    do_start();
    chk("err_clr", 32'(terr), 0);
    wait_busy("ia_busy", 20);
    step();
    step();
    do_start();
    wait_end("ia_end", 100);
    chk("ia_eoc", 32'(eoc_cnt), 2);
    chk("ia_sum", 32'(sum), 32'h1FF);
    chk("ia_cmp", 32'(complete), 1);

    // stop in CONV of sample 1
    clr();
    do_start();
    chk("sp_cmp0", 32'(complete), 0);
    wait_busy("sp_busy", 20);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("sp_cmp", 32'(complete), 1);
    repeat (15) step();
    chk("sp_eoc", 32'(eoc_cnt), 0);
    chk("sp_sum", 32'(sum), 0);
    chk("sp_soc", 32'(soc_cnt), 1);
    chk("sp_hold", 32'(complete), 1);

    // reset during second CONV
    clr();
    do_start();
    n = 0;
    while (eoc_cnt < 1 && n < 100) begin
      step();
      n++;
    end
    chk("rm_eoc1", 32'(n < 100), 1);
    wait_busy("rm_busy", 20);
    step();
    rst_n = 1'b0;
    #1;
    chk("rm_smp", 32'(sample), 0);
    chk("rm_sum", 32'(sum), 0);
    chk("rm_cmp", 32'(complete), 0);
    chk("rm_eocv", 32'(eoc), 0);
    chk("rm_soc", 32'(a.adc_soc), 0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rm_noeoc", 32'(eoc_cnt), 1);
    clr();
    do_start();
    wait_end("rm_end", 100);
    chk("rm_eoc", 32'(eoc_cnt), 2);
    chk("rm_sum2", 32'(sum), 32'h1FF);
    chk("rm_cmp2", 32'(complete), 1);

    // full scale, eight samples
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    n = 0;
    while (!(complete8 || terr8) && n < 200) begin
      step();
      n++;
    end
    chk("fs_end", 32'(n < 200), 1);
    chk("fs_eoc", 32'(eoc8_cnt), 8);
    chk("fs_sum", 32'(sum8), 32'h1FF8);
    chk("fs_smp", 32'(sample8), 32'h3FF);
    chk("fs_cmp", 32'(complete8), 1);
    chk("fs_terr", 32'(terr8), 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
